div_iter: RTL

Multi-cycle radix-2 restoring divider; the responder side of the execute stage's start/ready multiply-divide handshake. It accepts a 32-bit dividend and divisor when `start_i` is asserted, iterates one quotient bit per cycle, then presents `{remainder, quotient}` for exactly one cycle with `ready_o`. The execute stage stalls until `ready_o` and then writes the result into HI/LO. Signed and unsigned DIV/DIVU are supported, and both flush and annul abandon the operation.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_sign_fix.sv | 12 +
 rtl/div_iter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_ITERS = DIV_WIDTH;

    // Divide-by-zero quotient is all-ones; this is the fill bit.
    localparam logic DIV_ZERO_QUOT_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement: value_c = neg ? -value : value.
module div_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] value_c
);

    assign value_c = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/div_iter.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed and unsigned.
// Result {remainder, quotient} is presented for one cycle with ready_o.
module div_iter
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_ITERS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               annul_i,
    input  logic               start_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned SR_W  = 2 * WIDTH + 1;

    div_state_t       state;
    div_state_t       state_nxt;
    logic [SR_W-1:0]  rem_dvd;
    logic [SR_W-1:0]  shifted;
    logic [SR_W-1:0]  step;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dvd_mag_c;
    logic [WIDTH-1:0] dvs_mag_c;
    logic [WIDTH-1:0] rem_src;
    logic [WIDTH-1:0] rem_fix_c;
    logic [WIDTH-1:0] quo_fix_c;
    logic [CNT_W-1:0] cnt;
    logic             quo_neg;
    logic             rem_neg;
    logic             cancel;
    logic             last_iter;

    assign cancel    = flush | annul_i;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    div_sign_fix #(.WIDTH(WIDTH)) u_dvd_abs (
        .neg     (signed_div_i & opdata1_i[WIDTH-1]),
        .value   (opdata1_i),
        .value_c (dvd_mag_c)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_dvs_abs (
        .neg     (signed_div_i & opdata2_i[WIDTH-1]),
        .value   (opdata2_i),
        .value_c (dvs_mag_c)
    );

    // In DIVZERO the captured dividend magnitude is re-signed back to the raw dividend.
    assign rem_src = (state == DIVZERO) ? rem_dvd[WIDTH-1:0] : step[2*WIDTH-1:WIDTH];

    div_sign_fix #(.WIDTH(WIDTH)) u_rem_fix (
        .neg     (rem_neg),
        .value   (rem_src),
        .value_c (rem_fix_c)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_quo_fix (
        .neg     (quo_neg),
        .value   (step[WIDTH-1:0]),
        .value_c (quo_fix_c)
    );

    // One shift / trial-subtract / restore iteration.
    always_comb begin
        shifted = SR_W'({rem_dvd, 1'b0});
        diff    = shifted[SR_W-1:WIDTH] - {1'b0, dvs_mag};
        step    = shifted;
        if (!diff[WIDTH]) begin
            step = {diff, shifted[WIDTH-1:1], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cancel) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_i) state_nxt = (opdata2_i == '0) ? DIVZERO : ON;
                DIVZERO: state_nxt = END;
                ON:      if (last_iter) state_nxt = END;
                END:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath; the result is registered on entry to END so ready_o is high during END.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_dvd  <= '0;
            dvs_mag  <= '0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            cnt      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            ready_o <= 1'b0;
            if (!cancel) begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            rem_dvd <= {(WIDTH + 1)'(0), dvd_mag_c};
                            dvs_mag <= dvs_mag_c;
                            quo_neg <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            rem_neg <= signed_div_i & opdata1_i[WIDTH-1];
                            cnt     <= '0;
                        end
                    end
                    ON: begin
                        rem_dvd <= step;
                        cnt     <= cnt + CNT_W'(1);
                        if (last_iter) begin
                            result_o <= {rem_fix_c, quo_fix_c};
                            ready_o  <= 1'b1;
                        end
                    end
                    DIVZERO: begin
                        result_o <= {rem_fix_c, {WIDTH{DIV_ZERO_QUOT_FILL}}};
                        ready_o  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
